// File: rtl/msk_tk_lfsr_sched.sv
// Masked tweakey LFSR3 scheduler: a single byte-wide masked LFSR3 datapath walks
// the 8 state bytes once per round, for a programmable number of rounds.
module msk_tk_lfsr_sched #(
   parameter int d = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [64*d-1:0] tk_in,
   input  logic            start,
   input  logic [5:0]      n_rounds,
   output logic            busy,
   output logic            done,
   output logic [64*d-1:0] tk_out,
   output logic [5:0]      round_cnt
);

   localparam int BW = 8 * d;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [BW-1:0] bytes_q [8];
   logic [2:0]    ptr_q;
   logic [5:0]    n_lat_q;
   logic [5:0]    round_cnt_q;
   logic          busy_q;
   logic          done_q;

   logic          accept;
   logic          step;
   logic          wrap;
   logic          load_en;
   logic [BW-1:0] cur_byte;
   logic [BW-1:0] nxt_byte;

   // Share-wise LFSR3; each share is shifted independently so shares never mix.
   function automatic logic [BW-1:0] lfsr3(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = '0;
      for (int s = 0; s < d; s++) begin
         for (int j = 0; j < 7; j++) begin
            r[d*j+s] = b[d*(j+1)+s];
         end
         r[d*7+s] = b[s] ^ b[d*6+s];
      end
      return r;
   endfunction

   assign cur_byte = bytes_q[ptr_q];
   assign nxt_byte = lfsr3(cur_byte);
   assign load_en  = (state_q == IDLE) && load;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      wrap    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = (n_rounds == 6'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (ptr_q == 3'd7) begin
               wrap = 1'b1;
               if ((round_cnt_q + 6'd1) == n_lat_q) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // busy/done are registered decodes of the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   // Load and step are exclusive (IDLE vs RUN), so load+start uses the loaded value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            bytes_q[i] <= '0;
         end
         ptr_q       <= 3'd0;
         n_lat_q     <= 6'd0;
         round_cnt_q <= 6'd0;
      end else begin
         if (load_en) begin
            for (int i = 0; i < 8; i++) begin
               bytes_q[i] <= tk_in[BW*i +: BW];
            end
         end
         if (accept) begin
            n_lat_q     <= n_rounds;
            round_cnt_q <= 6'd0;
            ptr_q       <= 3'd0;
         end
         if (step) begin
            bytes_q[ptr_q] <= nxt_byte;
            ptr_q          <= ptr_q + 3'd1;
            if (wrap) begin
               round_cnt_q <= round_cnt_q + 6'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_out
      assign tk_out[BW*g +: BW] = bytes_q[g];
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign round_cnt = round_cnt_q;

endmodule

// File: doc/msk_tk_lfsr_sched.md
MSK_TK_LFSR_SCHED -- requirements
Module: msk_tk_lfsr_sched

Interface
REQ-001 SHALL have parameter: d, 2, number of Boolean shares per bit (d >= 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: load  input  1  capture tk_in into the state register.
REQ-005 SHALL have port: tk_in  input  64*d  8 masked bytes; byte i at [8*d*(i+1)-1 : 8*d*i].
REQ-006 SHALL have port: start  input  1  begin advancing the state by n_rounds LFSR3 rounds.
REQ-007 SHALL have port: n_rounds  input  6  round count, sampled on an accepted start.
REQ-008 SHALL have port: busy  output  1  high while rounds are being applied.
REQ-009 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port: tk_out  output  64*d  current masked state, same layout as tk_in.
REQ-011 SHALL have port: round_cnt  output  6  rounds completed in the current run.

Function
REQ-012 SHALL encode each masked byte share-interleaved per bit: bit j, share s is at local index d*j+s.
REQ-013 SHALL define LFSR3 on a masked byte, share-wise: new bit7 = bit0 XOR bit6; new bit k = old bit k+1 for k = 0..6; no fresh randomness; shares never combined.
REQ-014 SHALL instantiate exactly one byte-wide masked LFSR3 datapath, time-shared over the 8 bytes through a 3-bit byte pointer.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: load=1 SHALL write tk_in to the state at the next edge.
REQ-017 IDLE: start=1 SHALL latch n_rounds, clear round_cnt and the byte pointer, and go to RUN; if the latched n_rounds = 0, it SHALL go to DONE instead.
REQ-018 IDLE, load and start in the same cycle: the state SHALL take tk_in, and the run SHALL operate on the loaded value.
REQ-019 RUN: each cycle SHALL replace byte[ptr] with LFSR3(byte[ptr]) and increment ptr; other bytes SHALL hold.
REQ-020 RUN, ptr = 7: round_cnt SHALL increment and ptr SHALL wrap to 0; if round_cnt + 1 = latched n_rounds, the FSM SHALL go to DONE.
REQ-021 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-022 busy SHALL be 1 only in RUN; it SHALL be a registered state decode.
REQ-023 load and start SHALL be ignored in RUN and DONE; n_rounds changes after acceptance SHALL have no effect.
REQ-024 Latency: start accepted at edge t SHALL give RUN for 8*N cycles and done high for the cycle after the last RUN cycle. For N = 0, done SHALL be high in the cycle immediately after acceptance.
REQ-025 tk_out SHALL equal the state register directly, with no combinational path from tk_in.
REQ-026 round_cnt SHALL hold its final value through DONE and IDLE until the next accepted start.

Reset
REQ-027 rst = 1 at an edge SHALL force IDLE, state = 0, ptr = 0, round_cnt = 0, busy = 0, done = 0, regardless of the current state.
REQ-028 rst SHALL take priority over load and start in the same cycle.

Verification
REQ-029 d=2; load byte0 = 0x01 (share0), share1 = 0, other bytes 0; start with N=1 -> busy for 8 cycles; done pulses once; recombined byte0 = 0x80, all other bytes 0; round_cnt = 1.
REQ-030 d=2; every byte 0x41 in random sharings; N=1 -> every recombined byte = 0x20; each byte changes in exactly the cycle its ptr is selected.
REQ-031 byte0 = 0x01, N=2 -> recombined byte0 = 0x40 after 16 RUN cycles; done is high in cycle 17 after acceptance.
REQ-032 N=0 -> busy never rises; done is high the next cycle; state is unchanged.
REQ-033 Load+start in the same cycle with byte0 = 0x01 and N=1 -> result 0x80. start or load during RUN -> ignored; result unchanged.
REQ-034 rst asserted mid-RUN (ptr = 3) -> next cycle IDLE, tk_out = 0, round_cnt = 0, no done pulse.
